// File: rtl/lsb_mem_ctrl_pkg.sv
// Shared constants for the LSB memory controller: instruction type codes,
// funct3 load/store codes, IO window bounds, controller state encoding and
// the funct3 -> byte-count helper.
package lsb_mem_ctrl_pkg;

   localparam logic [6:0]  LD_TYPE = 7'b0000011;
   localparam logic [6:0]  S_TYPE  = 7'b0100011;

   localparam logic [2:0]  F3_LB  = 3'b000;
   localparam logic [2:0]  F3_LH  = 3'b001;
   localparam logic [2:0]  F3_LW  = 3'b010;
   localparam logic [2:0]  F3_LBU = 3'b100;
   localparam logic [2:0]  F3_LHU = 3'b101;
   localparam logic [2:0]  F3_SB  = 3'b000;
   localparam logic [2:0]  F3_SH  = 3'b001;
   localparam logic [2:0]  F3_SW  = 3'b010;

   // Stores into this window are held off while the IO buffer is full.
   localparam logic [31:0] IO_ADDR_LO = 32'h0003_0000;
   localparam logic [31:0] IO_ADDR_HI = 32'h0003_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Access width in bytes from funct3[1:0]: 00 -> 1, 01 -> 2, otherwise 4.
   function automatic logic [2:0] byte_count(input logic [2:0] op);
      case (op[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsb_mem_ctrl.sv
// Byte-serial memory controller between the load/store buffer and an 8-bit RAM.
// Latency (accept edge T): LB T+3, LW T+6, SB T+2, SW T+5; +1 per stalled cycle.
// Backpressure: accepts only in IDLE (welcome_lsb); rdy=0 freezes, io_buffer_full holds IO stores.
// Ports: clk/rst; rdy, rob_clear; request in_lsb_ready/op_in/instr_type_in/data_addr_in/data_in;
// completion welcome_lsb/cache_ready/cache_instr_type/cache_data_out; RAM mem_din/mem_dout/mem_a/mem_wr;
// io_buffer_full stall for the IO window.
module lsb_mem_ctrl
   import lsb_mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rob_clear,
   input  logic        in_lsb_ready,
   input  logic [2:0]  op_in,
   input  logic [6:0]  instr_type_in,
   input  logic [31:0] data_addr_in,
   input  logic [31:0] data_in,
   output logic        welcome_lsb,
   output logic        cache_ready,
   output logic [6:0]  cache_instr_type,
   output logic [31:0] cache_data_out,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [6:0]  type_q, type_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] buf_q, buf_d;
   logic [2:0]  k_q, k_d;
   logic        squash_q, squash_d;

   logic [2:0]  n;
   logic [31:0] cur_addr;
   logic        io_stall;

   function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] raw);
      case (op[1:0])
         2'b00:   return op[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   return op[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   assign n        = byte_count(op_q);
   assign cur_addr = addr_q + {29'd0, k_q};
   assign io_stall = io_buffer_full && (cur_addr >= IO_ADDR_LO) && (cur_addr <= IO_ADDR_HI);

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      type_d           = type_q;
      addr_d           = addr_q;
      data_d           = data_q;
      buf_d            = buf_q;
      k_d              = k_q;
      squash_d         = squash_q;
      welcome_lsb      = (state_q == ST_IDLE);
      cache_ready      = 1'b0;
      cache_instr_type = 7'd0;
      cache_data_out   = 32'd0;
      mem_wr           = 1'b0;
      mem_a            = 32'd0;
      mem_dout         = 8'd0;

      case (state_q)
         ST_IDLE: begin
            if (in_lsb_ready && !rob_clear &&
                (instr_type_in == LD_TYPE || instr_type_in == S_TYPE)) begin
               op_d     = op_in;
               type_d   = instr_type_in;
               addr_d   = data_addr_in;
               data_d   = data_in;
               buf_d    = 32'd0;
               k_d      = 3'd0;
               squash_d = 1'b0;
               state_d  = (instr_type_in == LD_TYPE) ? ST_LOAD : ST_STORE;
            end
         end

         ST_LOAD: begin
            // Byte k-1 arrives on mem_din while address k is issued. During a
            // stall the previous address is re-issued so that the byte seen in
            // the first cycle after the stall still belongs to lane k-1.
            if (!rdy)
               mem_a = (k_q == 3'd0) ? addr_q : cur_addr - 32'd1;
            else if (k_q < n)
               mem_a = cur_addr;
            if (k_q < n)
               k_d = k_q + 3'd1;
            case (k_q)
               3'd1:    buf_d[7:0]   = mem_din;
               3'd2:    buf_d[15:8]  = mem_din;
               3'd3:    buf_d[23:16] = mem_din;
               3'd4:    buf_d[31:24] = mem_din;
               default: ;
            endcase
            if (k_q == n)
               state_d = ST_DONE;
            if (rob_clear)
               state_d = ST_IDLE;
         end

         ST_STORE: begin
            mem_a = cur_addr;
            case (k_q[1:0])
               2'd0:    mem_dout = data_q[7:0];
               2'd1:    mem_dout = data_q[15:8];
               2'd2:    mem_dout = data_q[23:16];
               default: mem_dout = data_q[31:24];
            endcase
            if (!io_stall) begin
               mem_wr = 1'b1;
               k_d    = k_q + 3'd1;
               // A flushed store still completes in RAM but reports nothing.
               if (k_q == n - 3'd1)
                  state_d = (squash_q || rob_clear) ? ST_IDLE : ST_DONE;
            end
            if (rob_clear)
               squash_d = 1'b1;
         end

         ST_DONE: begin
            if (!(rob_clear && type_q == LD_TYPE)) begin
               cache_ready      = 1'b1;
               cache_instr_type = type_q;
               cache_data_out   = (type_q == LD_TYPE) ? load_extend(op_q, buf_q) : 32'd0;
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      if (!rdy)
         mem_wr = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= 3'd0;
         type_q   <= 7'd0;
         addr_q   <= 32'd0;
         data_q   <= 32'd0;
         buf_q    <= 32'd0;
         k_q      <= 3'd0;
         squash_q <= 1'b0;
      end else if (rdy) begin
         state_q  <= state_d;
         op_q     <= op_d;
         type_q   <= type_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         buf_q    <= buf_d;
         k_q      <= k_d;
         squash_q <= squash_d;
      end
   end

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed bench for lsb_mem_ctrl: byte RAM model, write log, completion monitor.
// Latency is measured in edges from the accepting edge to the edge sampling cache_ready.
// Every expected value below is hand-computed from the request and RAM contents.
module tb_lsb_mem_ctrl;
   import lsb_mem_ctrl_pkg::*;

   logic        clk, rst, rdy, rob_clear, in_lsb_ready, io_buffer_full;
   logic [2:0]  op_in;
   logic [6:0]  instr_type_in;
   logic [31:0] data_addr_in, data_in;
   logic        welcome_lsb, cache_ready, mem_wr;
   logic [6:0]  cache_instr_type;
   logic [31:0] cache_data_out, mem_a;
   logic [7:0]  mem_din, mem_dout;

   lsb_mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
      .in_lsb_ready(in_lsb_ready), .op_in(op_in), .instr_type_in(instr_type_in),
      .data_addr_in(data_addr_in), .data_in(data_in),
      .welcome_lsb(welcome_lsb), .cache_ready(cache_ready),
      .cache_instr_type(cache_instr_type), .cache_data_out(cache_data_out),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          cyc = 0;
   logic [7:0]  rom [0:4095];
   logic [31:0] wr_a [$];
   logic [7:0]  wr_d [$];
   int          wr_e [$];
   int          pulse_cnt = 0;
   int          last_edge = 0;
   logic [31:0] last_data = 32'd0;
   logic [6:0]  last_type = 7'd0;
   int          vec_cnt = 0;
   int          err_cnt = 0;

   // RAM read port: data for the address of the previous cycle; writes are logged.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      mem_din <= rom[mem_a[11:0]];
      if (mem_wr) begin
         wr_a.push_back(mem_a);
         wr_d.push_back(mem_dout);
         wr_e.push_back(cyc + 1);
      end
   end

   always @(negedge clk) begin
      if (cache_ready) begin
         pulse_cnt = pulse_cnt + 1;
         last_edge = cyc + 1;
         last_data = cache_data_out;
         last_type = cache_instr_type;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents a request for one cycle; t returns the accepting edge number.
   task automatic send(input logic [2:0] op, input logic [6:0] ty, input logic [31:0] a,
                       input logic [31:0] d, output int t);
      in_lsb_ready  = 1'b1;
      op_in         = op;
      instr_type_in = ty;
      data_addr_in  = a;
      data_in       = d;
      step(1);
      t = cyc;
      in_lsb_ready  = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int base);
      for (int i = 0; i < budget; i++) begin
         if (pulse_cnt > base) break;
         step(1);
      end
   endtask

   task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] exp, input int lat);
      int t, b;
      b = pulse_cnt;
      send(op, LD_TYPE, a, 32'd0, t);
      wait_done(30, b);
      step(3);
      chk({tag, " pulses"}, pulse_cnt - b, 1);
      chk({tag, " data"}, last_data, exp);
      chk({tag, " type"}, {25'd0, last_type}, {25'd0, LD_TYPE});
      chk({tag, " latency"}, last_edge - t, lat);
   endtask

   initial begin
      int t, b, w;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      rom[12'h100] = 8'h11; rom[12'h101] = 8'h22; rom[12'h102] = 8'h33; rom[12'h103] = 8'h44;
      rom[12'h005] = 8'h80;
      rom[12'h010] = 8'h00; rom[12'h011] = 8'h80;

      rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; in_lsb_ready = 1'b0; io_buffer_full = 1'b0;
      op_in = 3'd0; instr_type_in = 7'd0; data_addr_in = 32'd0; data_in = 32'd0;
      step(2);
      chk("reset welcome", {31'd0, welcome_lsb}, 1);
      chk("reset cache_ready", {31'd0, cache_ready}, 0);
      chk("reset mem_wr", {31'd0, mem_wr}, 0);
      chk("reset mem_a", mem_a, 32'd0);
      chk("reset data_out", cache_data_out, 32'd0);
      rst = 1'b0;
      step(1);

      do_load("LW", F3_LW, 32'h100, 32'h4433_2211, 6);
      do_load("LB", F3_LB, 32'h5, 32'hFFFF_FF80, 3);
      do_load("LBU", F3_LBU, 32'h5, 32'h0000_0080, 3);
      do_load("LH", F3_LH, 32'h10, 32'hFFFF_8000, 4);
      do_load("LHU", F3_LHU, 32'h10, 32'h0000_8000, 4);

      // SW: four consecutive byte writes, little-endian.
      b = pulse_cnt; w = wr_a.size();
      send(F3_SW, S_TYPE, 32'h200, 32'hDEAD_BEEF, t);
      wait_done(30, b);
      step(3);
      chk("SW writes", wr_a.size() - w, 4);
      if (wr_a.size() - w == 4) begin
         chk("SW a0", wr_a[w], 32'h200);   chk("SW d0", {24'd0, wr_d[w]}, 32'hEF);
         chk("SW a3", wr_a[w+3], 32'h203); chk("SW d1", {24'd0, wr_d[w+1]}, 32'hBE);
         chk("SW d2", {24'd0, wr_d[w+2]}, 32'hAD); chk("SW d3", {24'd0, wr_d[w+3]}, 32'hDE);
         chk("SW e0", wr_e[w] - t, 1);     chk("SW e3", wr_e[w+3] - t, 4);
      end
      chk("SW pulses", pulse_cnt - b, 1);
      chk("SW latency", last_edge - t, 5);
      chk("SW data", last_data, 32'd0);
      chk("SW type", {25'd0, last_type}, {25'd0, S_TYPE});

      // SB into the IO window with the IO buffer full for three cycles.
      b = pulse_cnt; w = wr_a.size();
      io_buffer_full = 1'b1;
      send(F3_SB, S_TYPE, 32'h3_0000, 32'h0000_00A5, t);
      step(1);
      chk("SB stall mem_wr", {31'd0, mem_wr}, 0);
      step(2);
      chk("SB stall writes", wr_a.size() - w, 0);
      io_buffer_full = 1'b0;
      wait_done(30, b);
      step(3);
      chk("SB writes", wr_a.size() - w, 1);
      if (wr_a.size() - w == 1) begin
         chk("SB addr", wr_a[w], 32'h3_0000);
         chk("SB data", {24'd0, wr_d[w]}, 32'hA5);
         chk("SB edge", wr_e[w] - t, 4);
      end
      chk("SB latency", last_edge - t, 5);

      // rob_clear in the second LW cycle.
      b = pulse_cnt;
      send(F3_LW, LD_TYPE, 32'h100, 32'd0, t);
      step(1);
      rob_clear = 1'b1;
      step(1);
      rob_clear = 1'b0;
      chk("LW flush idle", {31'd0, welcome_lsb}, 1);
      step(6);
      chk("LW flush pulses", pulse_cnt - b, 0);

      // rob_clear mid-SW: all four bytes still written, no completion.
      b = pulse_cnt; w = wr_a.size();
      send(F3_SW, S_TYPE, 32'h40, 32'h1122_3344, t);
      step(1);
      rob_clear = 1'b1;
      step(1);
      rob_clear = 1'b0;
      step(2);
      chk("SW flush idle", {31'd0, welcome_lsb}, 1);
      step(4);
      chk("SW flush writes", wr_a.size() - w, 4);
      if (wr_a.size() - w == 4) begin
         chk("SW flush d0", {24'd0, wr_d[w]}, 32'h44);
         chk("SW flush a3", wr_a[w+3], 32'h43);
         chk("SW flush d3", {24'd0, wr_d[w+3]}, 32'h11);
      end
      chk("SW flush pulses", pulse_cnt - b, 0);

      // A second request while busy is ignored; the next one after idle completes.
      b = pulse_cnt; w = wr_a.size();
      send(F3_LW, LD_TYPE, 32'h100, 32'd0, t);
      step(1);
      in_lsb_ready = 1'b1; op_in = F3_SB; instr_type_in = S_TYPE;
      data_addr_in = 32'h300; data_in = 32'h77;
      step(1);
      in_lsb_ready = 1'b0;
      wait_done(30, b);
      step(3);
      chk("busy pulses", pulse_cnt - b, 1);
      chk("busy data", last_data, 32'h4433_2211);
      chk("busy writes", wr_a.size() - w, 0);
      do_load("after busy LB", F3_LB, 32'h5, 32'hFFFF_FF80, 3);

      // rdy low for two cycles mid-LW.
      b = pulse_cnt;
      send(F3_LW, LD_TYPE, 32'h100, 32'd0, t);
      step(2);
      rdy = 1'b0;
      step(2);
      rdy = 1'b1;
      wait_done(30, b);
      step(3);
      chk("rdy pulses", pulse_cnt - b, 1);
      chk("rdy data", last_data, 32'h4433_2211);
      chk("rdy latency", last_edge - t, 8);

      // rdy low mid-SW: no write while frozen.
      b = pulse_cnt; w = wr_a.size();
      send(F3_SW, S_TYPE, 32'h80, 32'h0403_0201, t);
      step(1);
      rdy = 1'b0;
      #1;
      chk("rdy store mem_wr", {31'd0, mem_wr}, 0);
      step(2);
      rdy = 1'b1;
      wait_done(30, b);
      step(3);
      chk("rdy store writes", wr_a.size() - w, 4);
      chk("rdy store latency", last_edge - t, 7);

      // rob_clear in IDLE and an unknown type are both not accepted.
      b = pulse_cnt;
      in_lsb_ready = 1'b1; rob_clear = 1'b1; op_in = F3_LW; instr_type_in = LD_TYPE;
      data_addr_in = 32'h100;
      step(1);
      chk("clear idle welcome", {31'd0, welcome_lsb}, 1);
      rob_clear = 1'b0; instr_type_in = 7'b0110011;
      step(1);
      chk("bad type welcome", {31'd0, welcome_lsb}, 1);
      in_lsb_ready = 1'b0;
      step(6);
      chk("ignored pulses", pulse_cnt - b, 0);

      // rst mid-store abandons the remaining bytes.
      b = pulse_cnt; w = wr_a.size();
      send(F3_SW, S_TYPE, 32'h400, 32'hCAFE_F00D, t);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst welcome", {31'd0, welcome_lsb}, 1);
      chk("rst mem_wr", {31'd0, mem_wr}, 0);
      chk("rst mem_a", mem_a, 32'd0);
      step(5);
      chk("rst writes", wr_a.size() - w, 2);
      chk("rst pulses", pulse_cnt - b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
